ft_state_copier: RTL and testbench
==================================

FT_STATE_COPIER -- requirements
Module: ft_state_copier

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of GPRs (16 for RV32E); only x1..NREGS-1 are copied.
REQ-002 SHALL have parameter HALT_TIMEOUT, default 64, max cycles to wait for both cores halted.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  one-cycle request to copy architectural state from source core to destination core.
REQ-006 src_sel_i  in  1  source core (0 = core 0, 1 = core 1); destination is the other.
REQ-007 halt_o / resume_o  out  1 each  broadcast to both cores' debug_halt/debug_resume.
REQ-008 halted_i  in  2  debug_halted of core 1 (bit 1) and core 0 (bit 0).
REQ-009 dbg_req_o, dbg_we_o  out  2 each  per-core debug request and write enable.
REQ-010 dbg_gnt_i, dbg_rvalid_i  in  2 each  per-core debug grant and response valid.
REQ-011 dbg_addr_o  out  15  debug byte address, broadcast; dbg_wdata_o  out  32  write data, broadcast.
REQ-012 dbg_rdata0_i, dbg_rdata1_i  in  32 each  per-core debug read data.
REQ-013 busy_o  out  1  high from accepted start until DONE/ERR exit; done_o, err_o  out  1  one-cycle pulses.

Function
REQ-014 FSM states: IDLE, HALT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESUME, DONE, ERR.
REQ-015 IDLE: start_i=1 latches src_sel_i, idx=1, clears timeout counter, -> HALT; start_i outside IDLE ignored.
REQ-016 HALT: halt_o=1; halted_i==2'b11 -> RD_REQ; counter reaching HALT_TIMEOUT first -> ERR.
REQ-017 RD_REQ: dbg_req_o[src]=1, dbg_we_o=0, dbg_addr_o=0x400+4*idx; hold until dbg_gnt_i[src] -> RD_WAIT.
REQ-018 RD_WAIT: req low; on dbg_rvalid_i[src] capture src rdata into 32-bit buffer -> WR_REQ.
REQ-019 WR_REQ: dbg_req_o[dst]=1, dbg_we_o[dst]=1, same address, dbg_wdata_o=buffer; hold until dbg_gnt_i[dst] -> WR_WAIT.
REQ-020 WR_WAIT: on dbg_rvalid_i[dst]: idx<NREGS-1 -> idx+1, RD_REQ; else -> PC phase (REQ-031) or RESUME.
REQ-021 Addr, we, wdata SHALL be stable while req high; req never to both cores at once; dst never written before its rdata captured.
REQ-022 gnt in same cycle as req assertion is legal; min latency per register 4 cycles (req, gnt, rvalid, next).
REQ-023 RESUME: halt_o=0, resume_o=1 exactly one cycle -> DONE.
REQ-024 DONE: done_o=1 one cycle, busy_o=0 -> IDLE.
REQ-025 ERR: halt_o=0, resume_o=1 one cycle, err_o=1 one cycle, no writes issued -> IDLE.
REQ-026 halted_i dropping after HALT SHALL be ignored; gnt/rvalid on non-addressed core ignored.
REQ-027 idx width clog2(NREGS); idx SHALL never exceed NREGS-1 (no wrap).

Reset
REQ-028 rst_ni low SHALL force IDLE immediately; halt_o, resume_o, dbg_req_o, dbg_we_o, busy_o, done_o, err_o = 0; dbg_addr_o, dbg_wdata_o, buffer, idx, counter = 0.
REQ-029 Reset mid-transfer SHALL abandon it with no resume pulse; start_i sampled only after reset release.

Configuration
REQ-030 Macro FT_COPY_PC_EN selects PC copy.
REQ-031 Defined: after last GPR, one extra read/write pair at 0x2000 (NPC) using REQ-017..REQ-020 handshakes, then RESUME.
REQ-032 Undefined: WR_WAIT of last GPR goes directly to RESUME; address 0x2000 never driven.

Verification
REQ-033 NREGS=32, src=0, core0 xN=0x1000+N, zero-wait gnt/rvalid -> core1 x1..x31 = 0x1001..0x101F, done_o once, x0 never addressed.
REQ-034 src=1, gnt delayed 3 cycles each request -> addr/we/wdata stable while req high; core0 receives core1 values; total cycles > 31*7.
REQ-035 halted_i held 2'b01 for 64 cycles -> err_o pulse, resume_o pulse, zero dbg_we_o assertions.
REQ-036 rst_ni low during WR_REQ of x10 -> all outputs 0 next sample, no resume_o; new start_i completes full copy.
REQ-037 FT_COPY_PC_EN defined, src NPC=0x0000_0080 -> dst write at 0x2000 with 0x80 before resume_o; undefined -> no access to 0x2000.
REQ-038 start_i pulsed while busy_o=1 -> ignored, exactly one done_o.

Source files
------------

// File: rtl/ft_state_copier.sv
// ft_state_copier: halts both cores, copies GPRs x1..x(NREGS-1) from the
// selected source core to the other core through the debug port, then
// resumes both cores.
// Optional feature: define FT_COPY_PC_EN to copy the NPC (debug address
// 0x2000) after the last GPR.
module ft_state_copier #(
    parameter int NREGS        = 32,
    parameter int HALT_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        src_sel_i,
    output logic        halt_o,
    output logic        resume_o,
    input  logic [1:0]  halted_i,
    output logic [1:0]  dbg_req_o,
    output logic [1:0]  dbg_we_o,
    input  logic [1:0]  dbg_gnt_i,
    input  logic [1:0]  dbg_rvalid_i,
    output logic [14:0] dbg_addr_o,
    output logic [31:0] dbg_wdata_o,
    input  logic [31:0] dbg_rdata0_i,
    input  logic [31:0] dbg_rdata1_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(NREGS);
    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

    localparam logic [14:0] GPR_BASE = 15'h0400;
`ifdef FT_COPY_PC_EN
    localparam logic [14:0] NPC_ADDR = 15'h2000;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_HALT,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RESUME,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic               src_q, src_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_q, buf_d;
`ifdef FT_COPY_PC_EN
    logic               pc_phase_q, pc_phase_d;
`endif

    logic               dst;
    logic [14:0]        xfer_addr;

    assign dst = ~src_q;

    // Address of the register currently being transferred.
    always_comb begin
        xfer_addr = GPR_BASE + 15'({idx_q, 2'b00});
`ifdef FT_COPY_PC_EN
        if (pc_phase_q) begin
            xfer_addr = NPC_ADDR;
        end
`endif
    end

    // State and datapath registers.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            src_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
`ifdef FT_COPY_PC_EN
            pc_phase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
`ifdef FT_COPY_PC_EN
            pc_phase_q <= pc_phase_d;
`endif
        end
    end

    // Next-state, datapath updates and Moore outputs of the copy sequence.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
`ifdef FT_COPY_PC_EN
        pc_phase_d  = pc_phase_q;
`endif
        halt_o      = 1'b0;
        resume_o    = 1'b0;
        dbg_req_o   = 2'b00;
        dbg_we_o    = 2'b00;
        dbg_addr_o  = '0;
        dbg_wdata_o = buf_q;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        err_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    src_d   = src_sel_i;
                    idx_d   = IDX_W'(1);
                    cnt_d   = '0;
`ifdef FT_COPY_PC_EN
                    pc_phase_d = 1'b0;
`endif
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                halt_o = 1'b1;
                if (halted_i == 2'b11) begin
                    state_d = S_RD_REQ;
                end else if (cnt_q >= CNT_W'(HALT_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                halt_o           = 1'b1;
                dbg_req_o[src_q] = 1'b1;
                dbg_addr_o       = xfer_addr;
                if (dbg_gnt_i[src_q]) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                halt_o     = 1'b1;
                dbg_addr_o = xfer_addr;
                if (dbg_rvalid_i[src_q]) begin
                    buf_d   = src_q ? dbg_rdata1_i : dbg_rdata0_i;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                halt_o         = 1'b1;
                dbg_req_o[dst] = 1'b1;
                dbg_we_o[dst]  = 1'b1;
                dbg_addr_o     = xfer_addr;
                if (dbg_gnt_i[dst]) begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                halt_o     = 1'b1;
                dbg_addr_o = xfer_addr;
                if (dbg_rvalid_i[dst]) begin
`ifdef FT_COPY_PC_EN
                    if (pc_phase_q) begin
                        state_d = S_RESUME;
                    end else if (idx_q < IDX_W'(NREGS - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        pc_phase_d = 1'b1;
                        state_d    = S_RD_REQ;
                    end
`else
                    if (idx_q < IDX_W'(NREGS - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_RESUME;
                    end
`endif
                end
            end
            S_RESUME: begin
                resume_o = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                resume_o = 1'b1;
                err_o    = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ft_state_copier.sv
// tb_ft_state_copier: randomized self-checking bench. Two behavioural debug
// ports hold per-core register files; expected results are the source
// core's seeded register file copied into the destination.
module tb_ft_state_copier;

    localparam int NREGS        = 32;
    localparam int HALT_TIMEOUT = 64;
    localparam logic [14:0] NPC_A = 15'h2000;

    logic        clk, rst_n, start, src_sel, halt, resume, busy, done, err;
    logic [1:0]  halted, req, we, gnt, rvalid;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata [2];

    int vectors    = 0;
    int miscompares = 0;

    ft_state_copier #(.NREGS(NREGS), .HALT_TIMEOUT(HALT_TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_sel_i(src_sel),
        .halt_o(halt), .resume_o(resume), .halted_i(halted),
        .dbg_req_o(req), .dbg_we_o(we), .dbg_gnt_i(gnt), .dbg_rvalid_i(rvalid),
        .dbg_addr_o(addr), .dbg_wdata_o(wdata),
        .dbg_rdata0_i(rdata[0]), .dbg_rdata1_i(rdata[1]),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural cores ----------------
    logic [31:0] mem [2][NREGS];
    logic [31:0] npc [2];
    logic [31:0] seed [2][NREGS];
    logic [31:0] seed_npc [2];
    logic        load;
    int          gnt_delay;
    int          wcnt [2];

    function automatic bit is_gpr(logic [14:0] a);
        return a >= 15'h0400 && a < 15'(16'h0400 + 4 * NREGS) && a[1:0] == 2'b00;
    endfunction

    function automatic int gpr_of(logic [14:0] a);
        return (int'(a) - 'h400) / 4;
    endfunction

    always_comb begin
        for (int c = 0; c < 2; c++) gnt[c] = req[c] && (wcnt[c] >= gnt_delay);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid  <= 2'b00;
            wcnt[0] <= 0;
            wcnt[1] <= 0;
        end else begin
            if (load) begin
                for (int c = 0; c < 2; c++) begin
                    for (int n = 0; n < NREGS; n++) mem[c][n] <= seed[c][n];
                    npc[c] <= seed_npc[c];
                end
            end
            for (int c = 0; c < 2; c++) begin
                rvalid[c] <= 1'b0;
                if (req[c] && gnt[c]) begin
                    wcnt[c]   <= 0;
                    rvalid[c] <= 1'b1;
                    if (we[c]) begin
                        if (addr == NPC_A) npc[c] <= wdata;
                        else if (is_gpr(addr)) mem[c][gpr_of(addr)] <= wdata;
                    end else begin
                        rdata[c] <= (addr == NPC_A) ? npc[c]
                                  : is_gpr(addr) ? mem[c][gpr_of(addr)] : 32'hDEAD_BEEF;
                    end
                end else if (req[c]) begin
                    wcnt[c] <= wcnt[c] + 1;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int cyc = 0, done_cnt = 0, err_cnt = 0, resume_cnt = 0, we_cnt = 0;
    int both_cnt = 0, x0_cnt = 0, pc_addr_cnt = 0, unstable = 0;
    int resume_cyc = 0, pc_wr_cyc = 0;
    bit          pend = 1'b0;
    logic [1:0]  p_req, p_we;
    logic [14:0] p_addr;
    logic [31:0] p_wdata;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (done)   done_cnt++;
            if (err)    err_cnt++;
            if (resume) begin resume_cnt++; resume_cyc = cyc; end
            if (|we)    we_cnt++;
            if (req == 2'b11) both_cnt++;
            if (|req && addr == 15'h0400) x0_cnt++;
            if (|req && addr == NPC_A) pc_addr_cnt++;
            if (|(req & we & gnt) && addr == NPC_A) pc_wr_cyc = cyc;
            if (pend && (req != p_req || we != p_we || addr != p_addr || wdata != p_wdata))
                unstable++;
            pend    = |(req & ~gnt);
            p_req   = req;
            p_we    = we;
            p_addr  = addr;
            p_wdata = wdata;
        end else begin
            pend = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_cores(input bit src, input bit pattern);
        for (int c = 0; c < 2; c++) begin
            for (int n = 0; n < NREGS; n++) seed[c][n] = $urandom;
            seed_npc[c] = $urandom;
        end
        if (pattern) begin
            for (int n = 0; n < NREGS; n++) seed[src][n] = 32'h1000 + n;
            seed_npc[src] = 32'h0000_0080;
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input bit src);
        src_sel = src;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        src_sel = $urandom_range(0, 1);
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit timeout);
        int d0 = done_cnt;
        cycles = 0;
        while (done_cnt == d0 && cycles < limit) begin
            tick();
            cycles++;
        end
        timeout = (done_cnt == d0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        src_sel = 1'b0;
        halted = 2'b11;
        load = 1'b0;
        gnt_delay = 0;
        repeat (3) tick();
        vectors++; if ({halt, resume, busy, done, err} !== 5'b0) begin miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {halt, resume, busy, done, err}); end
        vectors++; if ({req, we} !== 4'b0) begin miscompares++;
            $display("FAIL reset_dbg: got %b expected 0000", {req, we}); end
        vectors++; if (addr !== 15'h0 || wdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", addr, wdata); end
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++; if (busy !== 1'b0 || halt !== 1'b0) begin miscompares++;
            $display("FAIL idle_after_reset: got busy=%b halt=%b expected 0/0", busy, halt); end
    endtask

    task automatic test_copy_zero_wait();
        int cycles, r0 = resume_cnt, d0 = done_cnt, x0 = x0_cnt, st = unstable, bc = both_cnt;
        int pa = pc_addr_cnt;
        bit to;
        bit src = 1'b0;
        gnt_delay = 0;
        load_cores(src, 1'b1);
        pulse_start(src);
        wait_done(3000, cycles, to);
        repeat (3) tick();
        vectors++; if (to) begin miscompares++;
            $display("FAIL zw_timeout: got no done_o in %0d cycles expected done", cycles); end
        for (int n = 1; n < NREGS; n++) begin
            vectors++; if (mem[1][n] !== 32'h1000 + n) begin miscompares++;
                $display("FAIL zw_x%0d: got %h expected %h", n, mem[1][n], 32'h1000 + n); end
        end
        vectors++; if (mem[1][0] !== seed[1][0]) begin miscompares++;
            $display("FAIL zw_x0_kept: got %h expected %h", mem[1][0], seed[1][0]); end
        vectors++; if (done_cnt - d0 != 1 || resume_cnt - r0 != 1) begin miscompares++;
            $display("FAIL zw_pulses: got done=%0d resume=%0d expected 1/1", done_cnt - d0, resume_cnt - r0); end
        vectors++; if (x0_cnt != x0 || both_cnt != bc || unstable != st) begin miscompares++;
            $display("FAIL zw_protocol: got x0=%0d both=%0d unstable=%0d expected 0/0/0",
                     x0_cnt - x0, both_cnt - bc, unstable - st); end
`ifdef FT_COPY_PC_EN
        vectors++; if (npc[1] !== 32'h80 || pc_wr_cyc >= resume_cyc || pc_wr_cyc == 0) begin miscompares++;
            $display("FAIL zw_npc: got npc=%h wr_cyc=%0d resume_cyc=%0d expected 80 written before resume",
                     npc[1], pc_wr_cyc, resume_cyc); end
`else
        vectors++; if (pc_addr_cnt != pa || npc[1] !== seed_npc[1]) begin miscompares++;
            $display("FAIL zw_no_npc: got accesses=%0d npc=%h expected 0/%h",
                     pc_addr_cnt - pa, npc[1], seed_npc[1]); end
`endif
    endtask

    task automatic test_copy_delayed();
        int cycles, st = unstable, bc = both_cnt;
        bit to;
        bit src = 1'b1;
        gnt_delay = 3;
        load_cores(src, 1'b0);
        pulse_start(src);
        wait_done(6000, cycles, to);
        repeat (3) tick();
        vectors++; if (to || cycles <= 31 * 7) begin miscompares++;
            $display("FAIL dly_cycles: got %0d timeout=%b expected >217 and done", cycles, to); end
        for (int n = 1; n < NREGS; n++) begin
            vectors++; if (mem[0][n] !== seed[1][n]) begin miscompares++;
                $display("FAIL dly_x%0d: got %h expected %h", n, mem[0][n], seed[1][n]); end
        end
        vectors++; if (unstable != st || both_cnt != bc) begin miscompares++;
            $display("FAIL dly_stable: got unstable=%0d both=%0d expected 0/0", unstable - st, both_cnt - bc); end
`ifdef FT_COPY_PC_EN
        vectors++; if (npc[0] !== seed_npc[1]) begin miscompares++;
            $display("FAIL dly_npc: got %h expected %h", npc[0], seed_npc[1]); end
`endif
        gnt_delay = 0;
    endtask

    task automatic test_halt_timeout();
        int e0 = err_cnt, r0 = resume_cnt, w0 = we_cnt, d0 = done_cnt, cycles = 0;
        halted = 2'b01;
        pulse_start(1'b0);
        while (err_cnt == e0 && cycles < 300) begin
            tick();
            cycles++;
        end
        repeat (3) tick();
        vectors++; if (err_cnt - e0 != 1 || cycles < HALT_TIMEOUT) begin miscompares++;
            $display("FAIL to_err: got err=%0d after %0d cycles expected 1 after >=%0d",
                     err_cnt - e0, cycles, HALT_TIMEOUT); end
        vectors++; if (resume_cnt - r0 != 1 || done_cnt != d0) begin miscompares++;
            $display("FAIL to_resume: got resume=%0d done=%0d expected 1/0", resume_cnt - r0, done_cnt - d0); end
        vectors++; if (we_cnt != w0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL to_no_write: got we=%0d busy=%b expected 0/0", we_cnt - w0, busy); end
        halted = 2'b11;
    endtask

    task automatic test_reset_mid();
        int cycles = 0, r0;
        bit to;
        bit src = $urandom_range(0, 1);
        load_cores(src, 1'b0);
        pulse_start(src);
        while (!(|we && addr == 15'h0400 + 15'd40) && cycles < 2000) begin
            tick();
            cycles++;
        end
        vectors++; if (cycles >= 2000) begin miscompares++;
            $display("FAIL rm_reach_x10: got no x10 write request expected one"); end
        r0 = resume_cnt;
        rst_n = 1'b0;
        #1;
        vectors++; if ({halt, resume, busy, done, err, req, we} !== 9'b0 || addr !== 15'h0 || wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rm_outputs: got ctl=%b addr=%h wdata=%h expected all zero",
                     {halt, resume, busy, done, err, req, we}, addr, wdata); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++; if (resume_cnt != r0) begin miscompares++;
            $display("FAIL rm_no_resume: got %0d resume pulses expected 0", resume_cnt - r0); end
        load_cores(src, 1'b0);
        pulse_start(src);
        wait_done(3000, cycles, to);
        repeat (3) tick();
        vectors++; if (to) begin miscompares++;
            $display("FAIL rm_restart: got no done_o expected done"); end
        for (int n = 1; n < NREGS; n++) begin
            vectors++; if (mem[!src][n] !== seed[src][n]) begin miscompares++;
                $display("FAIL rm_x%0d: got %h expected %h", n, mem[!src][n], seed[src][n]); end
        end
    endtask

    task automatic test_start_while_busy();
        int cycles, d0 = done_cnt;
        bit to;
        bit src = $urandom_range(0, 1);
        load_cores(src, 1'b0);
        pulse_start(src);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 30)) tick();
            vectors++; if (busy !== 1'b1) begin miscompares++;
                $display("FAIL bz_busy%0d: got %b expected 1", k, busy); end
            pulse_start(!src);
        end
        wait_done(3000, cycles, to);
        repeat (20) tick();
        vectors++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin miscompares++;
            $display("FAIL bz_done_once: got done=%0d busy=%b expected 1/0", done_cnt - d0, busy); end
        for (int n = 1; n < NREGS; n++) begin
            vectors++; if (mem[!src][n] !== seed[src][n]) begin miscompares++;
                $display("FAIL bz_x%0d: got %h expected %h", n, mem[!src][n], seed[src][n]); end
        end
    endtask

    initial begin
        test_reset();
        test_copy_zero_wait();
        test_copy_delayed();
        test_halt_timeout();
        test_reset_mid();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
